// File: rtl/sum_chain_pkg.sv
// Shared stage record and the single adder primitive for the sum-chain pipeline.
// Build option SUM_CHAIN_SAT_EN: adders clamp at the all-ones value instead of wrapping.
package sum_chain_pkg;

  localparam int MAX_W = 64;

  typedef logic [MAX_W-1:0] word_t;

  typedef struct packed {
    logic  valid;
    word_t a;
    word_t b;
    word_t c;
    word_t d;
  } stage_t;

  // Operands are assumed to already fit in w bits; the result is confined to w bits.
  function automatic word_t add_w(input word_t x, input word_t y, input int w);
    word_t          mask;
    logic [MAX_W:0] sum;
`ifdef SUM_CHAIN_SAT_EN
    logic           ovf;
`endif
    mask = (w >= MAX_W) ? '1 : ((word_t'(1) << w) - word_t'(1));
    sum  = {1'b0, x} + {1'b0, y};
`ifdef SUM_CHAIN_SAT_EN
    ovf = |(sum & ~{1'b0, mask});
    return ovf ? mask : (sum[MAX_W-1:0] & mask);
`else
    return sum[MAX_W-1:0] & mask;
`endif
  endfunction

endpackage

// File: rtl/sum_chain_ovr.sv
// Sticky override for the e output: a set/clear flag plus a value register feeding the e mux.
// Unaffected by SUM_CHAIN_SAT_EN; e only inherits saturation through f.
module sum_chain_ovr
  import sum_chain_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             force_set,
  input  logic             force_clr,
  input  logic [WIDTH-1:0] force_val,
  input  logic [WIDTH-1:0] f_in,
  output logic [WIDTH-1:0] e_out,
  output logic             forced
);

  logic             forced_q, forced_d;
  logic [WIDTH-1:0] ovr_q, ovr_d;

  // Set has priority over clear; clearing keeps the last loaded value.
  always_comb begin
    forced_d = forced_q;
    ovr_d    = ovr_q;
    if (force_set) begin
      forced_d = 1'b1;
      ovr_d    = force_val;
    end else if (force_clr) begin
      forced_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      forced_q <= 1'b0;
      ovr_q    <= '0;
    end else begin
      forced_q <= forced_d;
      ovr_q    <= ovr_d;
    end
  end

  assign e_out  = forced_q ? ovr_q : f_in;
  assign forced = forced_q;

endmodule

// File: rtl/sum_chain_pipe.sv
// Three-stage valid/ready sum chain: c=a+b, d=a+b+c, f=c+d, with sticky e override and handshake counter.
// Build option SUM_CHAIN_SAT_EN: every adder saturates instead of wrapping.
module sum_chain_pipe
  import sum_chain_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_c,
  output logic [WIDTH-1:0] out_d,
  output logic [WIDTH-1:0] out_f,
  output logic [WIDTH-1:0] out_e,
  input  logic             force_set,
  input  logic [WIDTH-1:0] force_val,
  input  logic             force_clr,
  output logic             forced,
  output logic [CNT_W-1:0] txn_cnt
);

  stage_t           stg_p1_q, stg_p1_d;
  stage_t           stg_p2_q, stg_p2_d;
  logic             vld_p3_q, vld_p3_d;
  logic [WIDTH-1:0] c_p3_q, c_p3_d;
  logic [WIDTH-1:0] d_p3_q, d_p3_d;
  logic [WIDTH-1:0] f_p3_q, f_p3_d;
  logic [CNT_W-1:0] txn_cnt_q, txn_cnt_d;
  logic             adv;
  word_t            f_sum;

  // One shared advance: the whole pipe moves or the whole pipe holds, bubbles included.
  assign adv      = !vld_p3_q || out_ready;
  assign in_ready = adv;

  always_comb begin
    stg_p1_d  = stg_p1_q;
    stg_p2_d  = stg_p2_q;
    vld_p3_d  = vld_p3_q;
    c_p3_d    = c_p3_q;
    d_p3_d    = d_p3_q;
    f_p3_d    = f_p3_q;
    txn_cnt_d = txn_cnt_q;
    f_sum     = add_w(stg_p2_q.c, stg_p2_q.d, WIDTH);
    if (adv) begin
      // stage 1: capture operands, form c
      stg_p1_d.valid = in_valid;
      stg_p1_d.a     = word_t'(in_a);
      stg_p1_d.b     = word_t'(in_b);
      stg_p1_d.c     = add_w(word_t'(in_a), word_t'(in_b), WIDTH);
      stg_p1_d.d     = '0;
      // stage 2: d as two chained adders so saturation applies at each step
      stg_p2_d       = stg_p1_q;
      stg_p2_d.d     = add_w(add_w(stg_p1_q.a, stg_p1_q.b, WIDTH), stg_p1_q.c, WIDTH);
      // stage 3: f and the output register
      vld_p3_d       = stg_p2_q.valid;
      c_p3_d         = stg_p2_q.c[WIDTH-1:0];
      d_p3_d         = stg_p2_q.d[WIDTH-1:0];
      f_p3_d         = f_sum[WIDTH-1:0];
    end
    if (vld_p3_q && out_ready) begin
      txn_cnt_d = txn_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stg_p1_q  <= '0;
      stg_p2_q  <= '0;
      vld_p3_q  <= 1'b0;
      c_p3_q    <= '0;
      d_p3_q    <= '0;
      f_p3_q    <= '0;
      txn_cnt_q <= '0;
    end else begin
      stg_p1_q  <= stg_p1_d;
      stg_p2_q  <= stg_p2_d;
      vld_p3_q  <= vld_p3_d;
      c_p3_q    <= c_p3_d;
      d_p3_q    <= d_p3_d;
      f_p3_q    <= f_p3_d;
      txn_cnt_q <= txn_cnt_d;
    end
  end

  // Fields carried for visibility only (a/b past stage 2, d in stage 1, high sum bits).
  logic unused_fields;
  assign unused_fields = ^{stg_p1_q.d, stg_p2_q.a, stg_p2_q.b, f_sum};

  sum_chain_ovr #(.WIDTH(WIDTH)) u_ovr (
    .clk       (clk),
    .rst_n     (rst_n),
    .force_set (force_set),
    .force_clr (force_clr),
    .force_val (force_val),
    .f_in      (f_p3_q),
    .e_out     (out_e),
    .forced    (forced)
  );

  assign out_valid = vld_p3_q;
  assign out_c     = c_p3_q;
  assign out_d     = d_p3_q;
  assign out_f     = f_p3_q;
  assign txn_cnt   = txn_cnt_q;

endmodule
